ps2_frame_rx: RTL and testbench

Parametrised serial frame receiver: the successor to the fixed 11-bit keyboard-code receiver. It runs entirely in the CLK domain, oversampling the external SCLK/SDATA pair. It decodes frames of configurable data width and parity mode, checks start, parity and stop bits, and detects stalled transfers with a timeout. Good codes are buffered in a small first-word-fall-through FIFO with a read handshake, and errors are reported as pulses plus a saturating counter.

---
 rtl/ps2_frame_rx.sv | 215 +++++++++++++++++++++
 tb/tb_ps2_frame_rx.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: oversampled serial frame receiver with configurable data width
// and parity, start/parity/stop checking, stall timeout, a small
// first-word-fall-through code FIFO and a saturating error counter.
module ps2_frame_rx #(
   parameter int DATA_W      = 8,
   parameter int PARITY_MODE = 1,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 4096,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              SCLK,
   input  logic              SDATA,
   input  logic              RD_EN,
   output logic [DATA_W-1:0] CODE,
   output logic              VALID,
   output logic              NEW_CODE,
   output logic              PARITY_ERR,
   output logic              FRAME_ERR,
   output logic              OVERFLOW,
   output logic [7:0]        ERR_CNT
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TO_W  = $clog2(TIMEOUT + 1);
   localparam int BIT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // synchronisers and edge detect
   logic [SYNC_STAGES-1:0] sclk_sync_reg;
   logic [SYNC_STAGES-1:0] sdata_sync_reg;
   logic                   sclk_prev_reg;
   logic                   fe_reg;
   logic                   sdata_bit_reg;

   // frame FSM
   state_t                 state_reg;
   logic [DATA_W-1:0]      shift_reg;
   logic [BIT_W-1:0]       bit_cnt_reg;
   logic                   par_ok_reg;
   logic [TO_W-1:0]        to_cnt_reg;

   // FIFO
   logic [DATA_W-1:0]      mem_reg [FIFO_DEPTH];
   logic [PTR_W-1:0]       wr_ptr_reg;
   logic [PTR_W-1:0]       rd_ptr_reg;
   logic [CNT_W-1:0]       count_reg;

   // registered status outputs
   logic                   new_code_reg;
   logic                   parity_err_reg;
   logic                   frame_err_reg;
   logic                   overflow_reg;
   logic [7:0]             err_cnt_reg;

   // per-cycle decisions
   logic                   timeout_hit;
   logic                   stop_event;
   logic                   parity_bad;
   logic                   push_req;
   logic                   pop;
   logic                   push_ok;
   logic                   drop;
   logic                   perr_now;
   logic                   ferr_now;
   logic [9:0]             err_sum;

   // Re-time the raw pins; both idle high so reset them to 1.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sclk_sync_reg  <= '1;
         sdata_sync_reg <= '1;
      end else begin
         sclk_sync_reg  <= {sclk_sync_reg[SYNC_STAGES-2:0], SCLK};
         sdata_sync_reg <= {sdata_sync_reg[SYNC_STAGES-2:0], SDATA};
      end
   end

   // Registered falling-edge strobe; the data bit is captured alongside it so
   // both refer to the same raw sampling instant.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sclk_prev_reg <= 1'b1;
         fe_reg        <= 1'b0;
         sdata_bit_reg <= 1'b1;
      end else begin
         sclk_prev_reg <= sclk_sync_reg[SYNC_STAGES-1];
         fe_reg        <= sclk_prev_reg & ~sclk_sync_reg[SYNC_STAGES-1];
         sdata_bit_reg <= sdata_sync_reg[SYNC_STAGES-1];
      end
   end

   // The stall counter holds "cycles since the last edge", so it fires exactly
   // TIMEOUT cycles after that edge once the output register is accounted for.
   assign timeout_hit = (state_reg != S_IDLE) && !fe_reg &&
                        (to_cnt_reg == TO_W'(TIMEOUT - 1));
   assign stop_event  = fe_reg && (state_reg == S_STOP);
   assign parity_bad  = (PARITY_MODE != 0) && !par_ok_reg;
   assign push_req    = stop_event && sdata_bit_reg && !parity_bad;
   assign pop         = RD_EN && (count_reg != '0);
   assign push_ok     = push_req && ((count_reg < CNT_W'(FIFO_DEPTH)) || pop);
   assign drop        = push_req && !push_ok;
   assign perr_now    = stop_event && parity_bad;
   assign ferr_now    = (stop_event && !sdata_bit_reg) || timeout_hit;
   assign err_sum     = {2'b00, err_cnt_reg} + {9'd0, perr_now} +
                        {9'd0, ferr_now} + {9'd0, drop};

   // Frame FSM: start, DATA_W data bits LSB first, optional parity, stop.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_reg   <= S_IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         par_ok_reg  <= 1'b1;
         to_cnt_reg  <= '0;
      end else begin
         if (fe_reg) begin
            to_cnt_reg <= TO_W'(1);
         end else if (state_reg != S_IDLE) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
         end

         if (timeout_hit) begin
            state_reg <= S_IDLE;
         end else if (fe_reg) begin
            case (state_reg)
               S_IDLE: begin
                  if (!sdata_bit_reg) begin
                     state_reg   <= S_DATA;
                     bit_cnt_reg <= '0;
                     par_ok_reg  <= 1'b1;
                  end
               end
               S_DATA: begin
                  shift_reg   <= {sdata_bit_reg, shift_reg[DATA_W-1:1]};
                  bit_cnt_reg <= bit_cnt_reg + BIT_W'(1);
                  if (bit_cnt_reg == BIT_W'(DATA_W - 1)) begin
                     state_reg <= (PARITY_MODE == 0) ? S_STOP : S_PARITY;
                  end
               end
               S_PARITY: begin
                  par_ok_reg <= (PARITY_MODE == 1) ? ((^shift_reg) ^ sdata_bit_reg)
                                                   : ~((^shift_reg) ^ sdata_bit_reg);
                  state_reg  <= S_STOP;
               end
               default: begin
                  state_reg <= S_IDLE;
               end
            endcase
         end
      end
   end

   // FIFO storage; no reset needed since reads are masked by occupancy.
   always_ff @(posedge CLK) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= shift_reg;
      end
   end

   // FIFO pointers and occupancy; a push and pop together leave it unchanged.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
         end
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Status pulses and the saturating error tally.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         new_code_reg   <= 1'b0;
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         overflow_reg   <= 1'b0;
         err_cnt_reg    <= '0;
      end else begin
         new_code_reg   <= push_ok;
         parity_err_reg <= perr_now;
         frame_err_reg  <= ferr_now;
         overflow_reg   <= drop;
         err_cnt_reg    <= (err_sum > 10'd255) ? 8'hFF : err_sum[7:0];
      end
   end

   assign VALID      = (count_reg != '0);
   assign CODE       = VALID ? mem_reg[rd_ptr_reg] : '0;
   assign NEW_CODE   = new_code_reg;
   assign PARITY_ERR = parity_err_reg;
   assign FRAME_ERR  = frame_err_reg;
   assign OVERFLOW   = overflow_reg;
   assign ERR_CNT    = err_cnt_reg;

endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed frames into two receiver configurations, checked
// every cycle against a queue-based reference model plus literal expectations.
`timescale 1ns/1ps
module tb_ps2_frame_rx;

   localparam int S    = 2;
   localparam int HALF = 6;
   localparam int TMO  = 4096;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] sclk = 2'b11;
   logic [1:0] sdata = 2'b11;
   logic [1:0] rd_en = 2'b00;

   logic [7:0] code0;
   logic [8:0] code1;
   logic       valid0, valid1, new0, new1, perr0, perr1, ferr0, ferr1, ovf0, ovf1;
   logic [7:0] cnt0, cnt1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct packed {
      logic [1:0]  inst;
      logic [31:0] cyc;
      logic [15:0] data;
      logic        push;
      logic        perr;
      logic        ferr;
   } ev_t;

   ev_t         evq[$];
   logic [15:0] mq0[$];
   logic [15:0] mq1[$];
   logic [1:0]  e_new  = '0;
   logic [1:0]  e_perr = '0;
   logic [1:0]  e_ferr = '0;
   logic [1:0]  e_ovf  = '0;
   logic [7:0]  e_cnt [2];

   ps2_frame_rx #(.DATA_W(8), .PARITY_MODE(1), .SYNC_STAGES(S), .TIMEOUT(TMO), .FIFO_DEPTH(4)) dut0 (
      .CLK(clk), .RST(rst_n), .SCLK(sclk[0]), .SDATA(sdata[0]), .RD_EN(rd_en[0]),
      .CODE(code0), .VALID(valid0), .NEW_CODE(new0), .PARITY_ERR(perr0),
      .FRAME_ERR(ferr0), .OVERFLOW(ovf0), .ERR_CNT(cnt0));

   ps2_frame_rx #(.DATA_W(9), .PARITY_MODE(0), .SYNC_STAGES(S), .TIMEOUT(TMO), .FIFO_DEPTH(2)) dut1 (
      .CLK(clk), .RST(rst_n), .SCLK(sclk[1]), .SDATA(sdata[1]), .RD_EN(rd_en[1]),
      .CODE(code1), .VALID(valid1), .NEW_CODE(new1), .PARITY_ERR(perr1),
      .FRAME_ERR(ferr1), .OVERFLOW(ovf1), .ERR_CNT(cnt1));

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s inst=%0d cyc=%0d got=%0h want=%0h", name, i, cyc, act, exp);
      end
   endtask

   function automatic int mq_size(input int i);
      return (i == 0) ? mq0.size() : mq1.size();
   endfunction

   function automatic logic [15:0] mq_head(input int i);
      if (i == 0) return (mq0.size() > 0) ? mq0[0] : 16'h0;
      return (mq1.size() > 0) ? mq1[0] : 16'h0;
   endfunction

   // Reference model: at each clock edge apply pops then scheduled frame results.
   initial begin
      logic rd;
      int   inc;
      ev_t  ev;
      e_cnt[0] = 8'd0;
      e_cnt[1] = 8'd0;
      forever begin
         @(posedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            e_new[i]  = 1'b0;
            e_perr[i] = 1'b0;
            e_ferr[i] = 1'b0;
            e_ovf[i]  = 1'b0;
            if (!rst_n) begin
               if (i == 0) mq0.delete(); else mq1.delete();
               for (int k = evq.size() - 1; k >= 0; k--)
                  if (int'(evq[k].inst) == i) evq.delete(k);
               e_cnt[i] = 8'd0;
            end else begin
               rd = rd_en[i];
               if (rd && mq_size(i) > 0) begin
                  if (i == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
               end
               for (int k = evq.size() - 1; k >= 0; k--) begin
                  if (int'(evq[k].inst) == i && evq[k].cyc == 32'(cyc)) begin
                     ev = evq[k];
                     evq.delete(k);
                     if (ev.perr) e_perr[i] = 1'b1;
                     if (ev.ferr) e_ferr[i] = 1'b1;
                     if (ev.push) begin
                        if (mq_size(i) < ((i == 0) ? 4 : 2)) begin
                           if (i == 0) mq0.push_back(ev.data); else mq1.push_back(ev.data);
                           e_new[i] = 1'b1;
                        end else begin
                           e_ovf[i] = 1'b1;
                        end
                     end
                  end
               end
               inc = int'(e_perr[i]) + int'(e_ferr[i]) + int'(e_ovf[i]);
               e_cnt[i] = (int'(e_cnt[i]) + inc > 255) ? 8'hFF : 8'(int'(e_cnt[i]) + inc);
            end
         end
      end
   end

   task automatic cmp_inst(input int i, input logic a_new, input logic a_perr, input logic a_ferr,
                           input logic a_ovf, input logic a_valid, input logic [15:0] a_code,
                           input logic [7:0] a_cnt);
      logic [15:0] x_code;
      logic        x_valid;
      if (!rst_n) begin
         chk("rst_new", i, 32'(a_new), 32'd0);
         chk("rst_perr", i, 32'(a_perr), 32'd0);
         chk("rst_ferr", i, 32'(a_ferr), 32'd0);
         chk("rst_ovf", i, 32'(a_ovf), 32'd0);
         chk("rst_valid", i, 32'(a_valid), 32'd0);
         chk("rst_code", i, 32'(a_code), 32'd0);
         chk("rst_errcnt", i, 32'(a_cnt), 32'd0);
      end else begin
         x_valid = (mq_size(i) > 0);
         x_code  = mq_head(i);
         chk("new_code", i, 32'(a_new), 32'(e_new[i]));
         chk("parity_err", i, 32'(a_perr), 32'(e_perr[i]));
         chk("frame_err", i, 32'(a_ferr), 32'(e_ferr[i]));
         chk("overflow", i, 32'(a_ovf), 32'(e_ovf[i]));
         chk("valid", i, 32'(a_valid), 32'(x_valid));
         chk("code", i, 32'(a_code), 32'(x_code));
         chk("err_cnt", i, 32'(a_cnt), 32'(e_cnt[i]));
      end
   endtask

   // Compare process: every cycle, away from the active edge.
   initial forever begin
      @(negedge clk);
      cmp_inst(0, new0, perr0, ferr0, ovf0, valid0, 16'(code0), cnt0);
      cmp_inst(1, new1, perr1, ferr1, ovf1, valid1, 16'(code1), cnt1);
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input int i, input logic b, output int fc);
      sdata[i] = b;
      wait_cyc(HALF);
      sclk[i] = 1'b0;
      fc = cyc;
      wait_cyc(HALF);
      sclk[i] = 1'b1;
   endtask

   // Full frame; the verdict is scheduled at the stop-bit fall.
   task automatic send_frame(input int i, input logic [15:0] data, input bit par_flip,
                             input logic stop_b, input bit rd_done);
      int          dw, pm, fc, ones;
      logic [15:0] d;
      logic        p;
      bit          par_ok;
      ev_t         ev;
      dw = (i == 0) ? 8 : 9;
      pm = (i == 0) ? 1 : 0;
      d  = data & ((i == 0) ? 16'h00FF : 16'h01FF);
      p  = 1'b0;
      if (pm == 1) p = ~(^d);
      if (pm == 2) p = ^d;
      if (par_flip) p = ~p;
      drive_bit(i, 1'b0, fc);
      for (int b = 0; b < dw; b++) drive_bit(i, d[b], fc);
      if (pm != 0) drive_bit(i, p, fc);
      ones   = $countones(d) + ((pm != 0) ? int'(p) : 0);
      par_ok = (pm == 0) || ((ones % 2) == ((pm == 1) ? 1 : 0));
      sdata[i] = stop_b;
      wait_cyc(HALF);
      sclk[i] = 1'b0;
      fc = cyc;
      ev.inst = 2'(i);
      ev.cyc  = 32'(fc + S + 2);
      ev.data = d;
      ev.push = par_ok && stop_b;
      ev.perr = !par_ok;
      ev.ferr = !stop_b;
      evq.push_back(ev);
      if (rd_done) begin
         wait_cyc(S + 1);
         rd_en[i] = 1'b1;
         wait_cyc(1);
         rd_en[i] = 1'b0;
         wait_cyc(HALF - S - 2);
      end else begin
         wait_cyc(HALF);
      end
      sclk[i] = 1'b1;
      sdata[i] = 1'b1;
      wait_cyc(HALF);
      $display("frame inst=%0d data=%0h par_flip=%0d stop=%0d rd_at_done=%0d", i, d, par_flip, stop_b, rd_done);
   endtask

   // Start bit plus nbits data bits, then SCLK parks high.
   task automatic send_partial(input int i, input logic [15:0] data, input int nbits, input bit expect_tmo);
      int  fc;
      ev_t ev;
      drive_bit(i, 1'b0, fc);
      for (int b = 0; b < nbits; b++) drive_bit(i, data[b], fc);
      sdata[i] = 1'b1;
      if (expect_tmo) begin
         ev.inst = 2'(i);
         ev.cyc  = 32'(fc + S + 1 + TMO);
         ev.data = 16'h0;
         ev.push = 1'b0;
         ev.perr = 1'b0;
         ev.ferr = 1'b1;
         evq.push_back(ev);
      end
      $display("partial inst=%0d data=%0h bits=%0d", i, data, nbits);
   endtask

   task automatic rd_pulse(input int i);
      rd_en[i] = 1'b1;
      wait_cyc(1);
      rd_en[i] = 1'b0;
      wait_cyc(1);
      $display("read inst=%0d", i);
   endtask

   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog cyc=%0d got=running want=done", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      wait_cyc(3);
      chk("lit_rst_valid", 0, 32'(valid0), 32'd0);
      chk("lit_rst_errcnt", 0, 32'(cnt0), 32'd0);
      rst_n = 1'b1;
      wait_cyc(5);

      // good frame
      send_frame(0, 16'h00A5, 1'b0, 1'b1, 1'b0);
      wait_cyc(2);
      chk("lit_good_code", 0, 32'(code0), 32'h0A5);
      chk("lit_good_valid", 0, 32'(valid0), 32'd1);
      chk("lit_good_errcnt", 0, 32'(cnt0), 32'd0);
      rd_pulse(0);
      chk("lit_pop_valid", 0, 32'(valid0), 32'd0);
      chk("lit_pop_code", 0, 32'(code0), 32'd0);

      // parity and stop errors
      send_frame(0, 16'h003C, 1'b1, 1'b1, 1'b0);
      chk("lit_perr_errcnt", 0, 32'(cnt0), 32'd1);
      chk("lit_perr_valid", 0, 32'(valid0), 32'd0);
      send_frame(0, 16'h003C, 1'b0, 1'b0, 1'b0);
      chk("lit_ferr_errcnt", 0, 32'(cnt0), 32'd2);
      send_frame(0, 16'h003C, 1'b1, 1'b0, 1'b0);
      chk("lit_both_errcnt", 0, 32'(cnt0), 32'd4);

      // timeout after 4 data bits
      send_partial(0, 16'h0009, 4, 1'b1);
      wait_cyc(TMO + 40);
      chk("lit_tmo_errcnt", 0, 32'(cnt0), 32'd5);
      send_frame(0, 16'h0012, 1'b0, 1'b1, 1'b0);
      chk("lit_after_tmo_code", 0, 32'(code0), 32'h012);
      rd_pulse(0);

      // overflow
      for (int k = 1; k <= 5; k++) send_frame(0, 16'(k), 1'b0, 1'b1, 1'b0);
      chk("lit_ovf_errcnt", 0, 32'(cnt0), 32'd6);
      for (int k = 1; k <= 4; k++) begin
         chk("lit_ovf_order", 0, 32'(code0), 32'(k));
         rd_pulse(0);
      end
      chk("lit_ovf_drained", 0, 32'(valid0), 32'd0);

      // simultaneous push and pop on a full FIFO
      for (int k = 0; k < 4; k++) send_frame(0, 16'(8'h11 + k), 1'b0, 1'b1, 1'b0);
      send_frame(0, 16'h0015, 1'b0, 1'b1, 1'b1);
      chk("lit_simul_code", 0, 32'(code0), 32'h012);
      chk("lit_simul_errcnt", 0, 32'(cnt0), 32'd6);

      // reset mid-frame with a full FIFO
      send_partial(0, 16'h00C3, 5, 1'b0);
      wait_cyc(2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("lit_midrst_valid", 0, 32'(valid0), 32'd0);
      chk("lit_midrst_code", 0, 32'(code0), 32'd0);
      chk("lit_midrst_errcnt", 0, 32'(cnt0), 32'd0);
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(20);
      chk("lit_release_errcnt", 0, 32'(cnt0), 32'd0);
      send_frame(0, 16'h007E, 1'b0, 1'b1, 1'b0);
      chk("lit_after_rst_code", 0, 32'(code0), 32'h07E);
      chk("lit_after_rst_errcnt", 0, 32'(cnt0), 32'd0);

      // 9-bit, no parity, depth 2
      send_frame(1, 16'h01AB, 1'b0, 1'b1, 1'b0);
      chk("lit_w9_code", 1, 32'(code1), 32'h1AB);
      send_frame(1, 16'h00F0, 1'b0, 1'b1, 1'b0);
      send_frame(1, 16'h0155, 1'b0, 1'b1, 1'b0);
      chk("lit_w9_errcnt", 1, 32'(cnt1), 32'd1);
      chk("lit_w9_head", 1, 32'(code1), 32'h1AB);
      rd_pulse(1);
      chk("lit_w9_second", 1, 32'(code1), 32'h0F0);
      rd_pulse(1);
      chk("lit_w9_empty", 1, 32'(valid1), 32'd0);

      wait_cyc(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
